vga_scan_compositor: RTL and testbench



---
 rtl/vga_scan_compositor.sv | 128 ++++++++++++
 tb/tb_vga_scan_compositor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vga_scan_compositor.sv
// rtl/vga_scan_compositor.sv - raster timing generator and fixed-priority sprite compositor
module vga_scan_compositor #(
    parameter int          H_ACTIVE   = 1024,
    parameter int          H_FP       = 24,
    parameter int          H_SYNC     = 136,
    parameter int          H_BP       = 160,
    parameter int          V_ACTIVE   = 768,
    parameter int          V_FP       = 3,
    parameter int          V_SYNC     = 6,
    parameter int          V_BP       = 29,
    parameter int          NUM_LAYERS = 4,
    parameter int          PIPE_LAT   = 3,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic                       pixel_clk_in,
    input  logic                       rst_n_in,
    input  logic [12*NUM_LAYERS-1:0]   layer_pixels_in,
    output logic [10:0]                hcount_out,
    output logic [9:0]                 vcount_out,
    output logic                       frame_start_out,
    output logic                       blank_out,
    output logic [11:0]                vga_rgb_out,
    output logic                       vga_hs_out,
    output logic                       vga_vs_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line entry layout: {blank, hs, vs}
    localparam int BL = 2;
    localparam int HS = 1;
    localparam int VS = 0;

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        frame_start_q, frame_start_d;
    logic        h_wrap, v_wrap;
    logic        raw_blank, raw_hs, raw_vs;

    logic [PIPE_LAT-1:0][2:0] dly_q, dly_d;

    logic [11:0] sel_color;
    logic [11:0] rgb_q;
    logic        blank_q, hs_q, vs_q;

    // Scan counters advance; frame pulse is registered so it coincides with (0,0) after a wrap only
    always_comb begin
        h_wrap        = (hcount_q == H_MAX);
        v_wrap        = (vcount_q == V_MAX);
        hcount_d      = h_wrap ? 11'd0 : hcount_q + 11'd1;
        vcount_d      = vcount_q;
        if (h_wrap) begin
            vcount_d  = v_wrap ? 10'd0 : vcount_q + 10'd1;
        end
        frame_start_d = h_wrap && v_wrap;
    end

    // Raw timing decoded from the current scan position
    always_comb begin
        raw_blank = (hcount_q >= H_ACT) || (vcount_q >= V_ACT);
        raw_hs    = !((hcount_q >= HS_START) && (hcount_q < HS_END));
        raw_vs    = !((vcount_q >= VS_START) && (vcount_q < VS_END));
    end

    // Shift raw timing along so it meets the sprite pixels for the same count
    always_comb begin
        dly_d    = dly_q;
        dly_d[0] = {raw_blank, raw_hs, raw_vs};
        for (int i = 1; i < PIPE_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // Lowest-indexed opaque layer wins; blanking forces black
    always_comb begin
        sel_color = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_pixels_in[12*i +: 12] != 12'h000) begin
                sel_color = layer_pixels_in[12*i +: 12];
            end
        end
        if (dly_q[PIPE_LAT-1][BL]) begin
            sel_color = 12'h000;
        end
    end

    // State registers; reset leaves the delay line full of inactive timing so no partial sync escapes
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 10'd0;
            frame_start_q <= 1'b0;
            dly_q         <= '1;
            rgb_q         <= 12'h000;
            blank_q       <= 1'b1;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
            dly_q         <= dly_d;
            rgb_q         <= sel_color;
            blank_q       <= dly_q[PIPE_LAT-1][BL];
            hs_q          <= dly_q[PIPE_LAT-1][HS];
            vs_q          <= dly_q[PIPE_LAT-1][VS];
        end
    end

    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign frame_start_out = frame_start_q;
    assign vga_rgb_out     = rgb_q;
    assign blank_out       = blank_q;
    assign vga_hs_out      = hs_q;
    assign vga_vs_out      = vs_q;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// tb/tb_vga_scan_compositor.sv - randomized bench for vga_scan_compositor against a timing model
module tb_vga_scan_compositor;

    localparam int          HA  = 20;
    localparam int          HFP = 3;
    localparam int          HSW = 5;
    localparam int          HBP = 4;
    localparam int          VA  = 10;
    localparam int          VFP = 2;
    localparam int          VSW = 3;
    localparam int          VBP = 2;
    localparam int          NL  = 4;
    localparam int          PL  = 3;
    localparam logic [11:0] BG  = 12'h5A3;
    localparam int          HT  = HA + HFP + HSW + HBP;
    localparam int          VT  = VA + VFP + VSW + VBP;
    localparam int          FT  = HT * VT;

    logic                 clk;
    logic                 rst_n;
    logic [12*NL-1:0]     layers;
    logic [10:0]          hcount;
    logic [9:0]           vcount;
    logic                 frame_start;
    logic                 blank;
    logic [11:0]          rgb;
    logic                 hs;
    logic                 vs;

    int checks;
    int errors;
    int n;
    logic [12*NL-1:0] drv_prev;

    vga_scan_compositor #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .NUM_LAYERS(NL), .PIPE_LAT(PL), .BG_COLOR(BG)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_n_in       (rst_n),
        .layer_pixels_in(layers),
        .hcount_out     (hcount),
        .vcount_out     (vcount),
        .frame_start_out(frame_start),
        .blank_out      (blank),
        .vga_rgb_out    (rgb),
        .vga_hs_out     (hs),
        .vga_vs_out     (vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic logic [11:0] compose(input logic [12*NL-1:0] px);
        for (int i = 0; i < NL; i++) begin
            if (px[12*i +: 12] != 12'h000) return px[12*i +: 12];
        end
        return BG;
    endfunction

    function automatic logic [12*NL-1:0] rand_layers();
        logic [12*NL-1:0] v;
        for (int i = 0; i < NL; i++) begin
            v[12*i +: 12] = ($urandom_range(1, 0) == 0) ? 12'h000 : 12'($urandom_range(4095, 1));
        end
        return v;
    endfunction

    task automatic check_reset_values(input string where);
        chk({where, "_hcount"}, 32'(hcount), 32'd0);
        chk({where, "_vcount"}, 32'(vcount), 32'd0);
        chk({where, "_fstart"}, 32'(frame_start), 32'd0);
        chk({where, "_rgb"}, 32'(rgb), 32'd0);
        chk({where, "_blank"}, 32'(blank), 32'd1);
        chk({where, "_hs"}, 32'(hs), 32'd1);
        chk({where, "_vs"}, 32'(vs), 32'd1);
    endtask

    // Expected outputs at interval n since reset release, from frame geometry alone
    task automatic check_cycle();
        int h, v, m, hm, vm;
        logic e_bl, e_hs, e_vs;
        logic [11:0] e_rgb;
        h = n % HT;
        v = (n / HT) % VT;
        chk("hcount", 32'(hcount), 32'(h));
        chk("vcount", 32'(vcount), 32'(v));
        chk("frame_start", 32'(frame_start), 32'((n != 0) && (n % FT == 0)));
        if (n >= PL + 1) begin
            m    = n - PL - 1;
            hm   = m % HT;
            vm   = (m / HT) % VT;
            e_bl = (hm >= HA) || (vm >= VA);
            e_hs = !((hm >= HA + HFP) && (hm < HA + HFP + HSW));
            e_vs = !((vm >= VA + VFP) && (vm < VA + VFP + VSW));
            e_rgb = e_bl ? 12'h000 : compose(drv_prev);
        end else begin
            e_bl  = 1'b1;
            e_hs  = 1'b1;
            e_vs  = 1'b1;
            e_rgb = 12'h000;
        end
        chk("blank", 32'(blank), 32'(e_bl));
        chk("hsync", 32'(hs), 32'(e_hs));
        chk("vsync", 32'(vs), 32'(e_vs));
        chk("rgb", 32'(rgb), 32'(e_rgb));
    endtask

    task automatic run_cycles(input int count);
        logic [12*NL-1:0] drv;
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            check_cycle();
            drv      = rand_layers();
            layers   = drv;
            drv_prev = drv;
            n++;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        n        = 0;
        rst_n    = 1'b0;
        layers   = '0;
        drv_prev = '0;

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            layers = rand_layers();
            check_reset_values("in_reset");
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        run_cycles(3 * FT + 20);

        // Asynchronous mid-frame reset inside active video
        run_cycles(5 * HT + 10);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(posedge clk);
        @(negedge clk);
        check_reset_values("held_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        run_cycles(2 * FT + 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
